booth2_operand_stage: RTL
=========================

// Module: booth2_operand_stage
// PURPOSE
//  Pipelined operand front end of the 16x16 Booth radix-4 / Wallace multiplier.
//  Accepts signed multiplicand A and multiplier B with a valid/ready handshake.
//  Registers both operands, computes the 17-bit negated multiplicand (-A) and the
//  Booth codes for all partial products. Drives the pp1 decoder and the
//  pp2..ppN decoders directly from registered outputs.
// PARAMETERS
//  WIDTH  16  operand width; even, >=4. NPP = WIDTH/2 is a derived localparam.
//  TAG_W  4   width of the opaque sideband tag carried alongside each operand pair.
// PORTS
//  sys_clk    in   1              clock; all state updates on its rising edge
//  sys_rst_n  in   1              asynchronous, active-low reset
//  in_valid   in   1              upstream operand pair valid
//  in_ready   out  1              stage can accept; transfer when in_valid&in_ready
//  in_a       in   WIDTH          multiplicand A, two's complement
//  in_b       in   WIDTH          multiplier B, two's complement
//  in_tag     in   TAG_W          sideband tag
//  out_valid  out  1              outputs below are valid
//  out_ready  in   1              downstream accepts; transfer when out_valid&out_ready
//  out_a      out  WIDTH          registered A
//  out_inv_a  out  WIDTH+1        -{A[MSB],A}, 17-bit two's complement
//  code_pp1   out  2              {B[1],B[0]}; implicit B[-1]=0
//  code_ppn   out  3*(NPP-1)      slice k-1 (k=1..NPP-1) = {B[2k+1],B[2k],B[2k-1]}; ppN in MSBs
//  out_tag    out  TAG_W          tag of the pair on the output
//  busy       out  1              s1_valid|s2_valid
// BEHAVIOUR
//  - Two register stages: S1 holds the raw operands and tag. S2 holds the outputs.
//  - s2_load  = s1_valid & (~s2_valid | out_ready).
//  - in_ready = ~s1_valid | s2_load. This is a combinational path from out_ready
//    and is required for full throughput.
//  - S1 loads on in_valid&in_ready. s1_valid clears on s2_load without a simultaneous accept.
//  - s2_valid sets on s2_load and clears on out_ready without s2_load.
//  - Simultaneous accept and hand-off in one cycle: both stages update, so there is
//    no bubble and no loss.
//  - Latency is 2 cycles from the accept edge to out_valid with no stall.
//    Throughput is 1 pair per cycle.
//  - While out_valid&~out_ready, every S2 output is held bit-stable.
//  - Negation: out_inv_a = ~{A[MSB],A} + 1, computed in S1->S2 logic.
//    A=16'h8000 gives 17'h08000, with no overflow. A=0 gives 17'h00000.
//  - Booth codes are bit slices only; no decode happens in this block.
//  - Reset (async assert, sync deassert handled upstream):
//    s1_valid=s2_valid=0, all data registers=0, so code_pp1=0 and code_ppn=0 (zero PPs).
//    out_valid=0 and busy=0. in_ready=1 on the first cycle after deassert.
//  - Reset mid-operation discards in-flight pairs; nothing is replayed.
//  - in_valid&~in_ready: the input is not sampled. Upstream holds its data.
// STRUCTURE
//  - Shared package booth2_pkg holds:
//    - localparams for WIDTH=16 and NPP=8
//    - Booth code constants: CODE_ZERO, CODE_PA, CODE_P2A, CODE_N2A, CODE_NA
//    - the pack/unpack index function for code_ppn slices
//  - One combinational sub-module, booth2_code_slicer (B -> code_pp1, code_ppn).
//    The negation and the handshake stay in this module.
// TESTING
//  1. A=16'h8000, B=16'h0003, tag=5, out_ready=1
//     -> 2 cycles later out_inv_a=17'h08000, code_pp1=2'b11,
//        ppn slice0=3'b001, other slices=0, out_tag=5.
//  2. A=16'h0001, B=16'hFFFF
//     -> out_inv_a=17'h1FFFF, code_pp1=2'b11, all code_ppn slices=3'b111.
//  3. 8 back-to-back pairs with out_ready=1
//     -> in_ready stays 1, out_valid high for 8 consecutive cycles starting
//        2 cycles after the first accept, order and tags preserved.
//  4. out_ready=0 for 6 cycles while offering 4 pairs
//     -> exactly 2 accepted, in_ready=0 afterwards, S2 outputs stable.
//        Release -> remaining pairs emerge in order, none lost or duplicated.
//  5. Assert sys_rst_n=0 with both stages full
//     -> same cycle out_valid=0, busy=0, codes=0. After release, in_ready=1 and
//        a new pair appears with 2-cycle latency.
//  6. Random A/B with random in_valid/out_ready, 10k pairs
//     -> scoreboard matches out_inv_a == -A and the code slices against a reference
//        model. Also check the Booth identity
//        sum(decode(code_k)*A*4^k) == A*B.

Source files
------------

// File: rtl/booth2_pkg.sv
// Shared definitions for the Booth radix-4 multiplier front end: default sizes,
// canonical Booth triplet values and the code_ppn slice index helper.
package booth2_pkg;

    localparam int WIDTH = 16;
    localparam int NPP   = WIDTH / 2;

    // Canonical {b[2k+1], b[2k], b[2k-1]} triplets for each partial-product action
    localparam logic [2:0] CODE_ZERO = 3'b000;
    localparam logic [2:0] CODE_PA   = 3'b001;
    localparam logic [2:0] CODE_P2A  = 3'b011;
    localparam logic [2:0] CODE_N2A  = 3'b100;
    localparam logic [2:0] CODE_NA   = 3'b101;

    // LSB of the slice for partial product k (k = 1..NPP-1) inside code_ppn
    function automatic int ppn_lsb(input int k);
        return 3 * (k - 1);
    endfunction

endpackage

// File: rtl/booth2_code_slicer.sv
// Pure wiring: cuts multiplier B into overlapping Booth triplets.
// pp1 uses an implicit B[-1] = 0, so only its two real bits are emitted.
module booth2_code_slicer #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]             b,
    output logic [1:0]                   code_pp1,
    output logic [3*(WIDTH/2-1)-1:0]     code_ppn
);
    import booth2_pkg::*;

    localparam int NPP = WIDTH / 2;

    assign code_pp1 = b[1:0];

    for (genvar k = 1; k < NPP; k++) begin : g_slice
        assign code_ppn[ppn_lsb(k) +: 3] = b[2*k+1 -: 3];
    end

endmodule

// File: rtl/booth2_operand_stage.sv
// Two-stage operand front end of the 16x16 Booth radix-4 multiplier: registers
// A/B/tag, then presents A, -A (17 bit) and the Booth codes from registers.
module booth2_operand_stage #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_a,
    input  logic [WIDTH-1:0]             in_b,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_a,
    output logic [WIDTH:0]               out_inv_a,
    output logic [1:0]                   code_pp1,
    output logic [3*(WIDTH/2-1)-1:0]     code_ppn,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         busy
);
    import booth2_pkg::*;

    localparam int NPP = WIDTH / 2;

    logic                     s1_valid;
    logic [WIDTH-1:0]         s1_a;
    logic [WIDTH-1:0]         s1_b;
    logic [TAG_W-1:0]         s1_tag;
    logic                     s2_valid;
    logic                     accept;
    logic                     s2_load;
    logic [WIDTH:0]           inv_a_d;
    logic [1:0]               pp1_d;
    logic [3*(NPP-1)-1:0]     ppn_d;

    // Handshake: a beat moves on a rising edge where valid & ready are both high.
    // A producer holds valid and its data until that edge; ready never waits on
    // valid. in_ready looks through S1 to out_ready so a full pipe still streams.
    assign s2_load  = s1_valid & (~s2_valid | out_ready);
    assign in_ready = ~s1_valid | s2_load;
    assign accept   = in_valid & in_ready;

    assign out_valid = s2_valid;
    assign busy      = s1_valid | s2_valid;

    // Sign-extend first so that -(-2^(WIDTH-1)) is representable
    assign inv_a_d = ~{s1_a[WIDTH-1], s1_a} + (WIDTH+1)'(1);

    booth2_code_slicer #(.WIDTH(WIDTH)) u_slicer (
        .b        (s1_b),
        .code_pp1 (pp1_d),
        .code_ppn (ppn_d)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else begin
            if (accept) begin
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_tag <= in_tag;
            end
            if (accept)
                s1_valid <= 1'b1;
            else if (s2_load)
                s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s2_valid  <= 1'b0;
            out_a     <= '0;
            out_inv_a <= '0;
            code_pp1  <= '0;
            code_ppn  <= '0;
            out_tag   <= '0;
        end else begin
            if (s2_load) begin
                s2_valid  <= 1'b1;
                out_a     <= s1_a;
                out_inv_a <= inv_a_d;
                code_pp1  <= pp1_d;
                code_ppn  <= ppn_d;
                out_tag   <= s1_tag;
            end else if (out_ready) begin
                s2_valid  <= 1'b0;
            end
        end
    end

endmodule
